// File: rtl/types_pkg.sv
// Shared types for the memory functional unit responder: funct3 codes,
// FSM state, latched load request, and small store/age helpers.
package types_pkg;

    localparam logic [2:0] F3_LB  = 3'b000;
    localparam logic [2:0] F3_LH  = 3'b001;
    localparam logic [2:0] F3_LW  = 3'b010;
    localparam logic [2:0] F3_LBU = 3'b100;
    localparam logic [2:0] F3_LHU = 3'b101;

    localparam logic [2:0] F3_SB  = 3'b000;
    localparam logic [2:0] F3_SH  = 3'b001;
    localparam logic [2:0] F3_SW  = 3'b010;

    typedef enum logic [1:0] {
        IDLE,
        WAIT,
        RESP
    } dmem_state_t;

    typedef struct packed {
        logic [31:0] addr;
        logic [2:0]  funct3;
        logic [6:0]  pd;
        logic [4:0]  rob;
    } dmem_req_t;

    // Byte enables for a store; misaligned SH/SW are aligned down.
    function automatic logic [3:0] store_be(input logic [2:0] funct3, input logic [1:0] addr_lo);
        logic [3:0] be;
        case (funct3)
            F3_SB:   be = 4'b0001 << addr_lo;
            F3_SH:   be = addr_lo[1] ? 4'b1100 : 4'b0011;
            F3_SW:   be = 4'b1111;
            default: be = 4'b0000;
        endcase
        return be;
    endfunction

    // Replicate the store's low bits so every enabled lane sees its data.
    function automatic logic [31:0] store_lanes(input logic [2:0] funct3, input logic [31:0] data);
        logic [31:0] w;
        case (funct3)
            F3_SB:   w = {4{data[7:0]}};
            F3_SH:   w = {2{data[15:0]}};
            default: w = data;
        endcase
        return w;
    endfunction

    // Distance from the ROB head; larger means younger. 5-bit wrap does the mod 32.
    function automatic logic [4:0] rob_age(input logic [4:0] tag, input logic [4:0] head);
        return tag - head;
    endfunction

endpackage

// File: rtl/dmem_lane_extract.sv
// Combinational load-lane selection: picks the byte/half from a word,
// sign- or zero-extends it, and flags misaligned or unknown funct3.
module dmem_lane_extract
    import types_pkg::*;
(
    input  logic [31:0] word,
    input  logic [2:0]  funct3,
    input  logic [1:0]  addr_lo,
    output logic [31:0] data,
    output logic        err
);

    logic [7:0]  byte_v;
    logic [15:0] half_v;

    // Select lane and extend; errored loads return zero data.
    always_comb begin
        byte_v = word[{addr_lo, 3'b000} +: 8];
        half_v = addr_lo[1] ? word[31:16] : word[15:0];
        data   = '0;
        err    = 1'b0;
        case (funct3)
            F3_LB:  data = {{24{byte_v[7]}}, byte_v};
            F3_LBU: data = {24'h0, byte_v};
            F3_LH: begin
                if (addr_lo[0]) err = 1'b1;
                else            data = {{16{half_v[15]}}, half_v};
            end
            F3_LHU: begin
                if (addr_lo[0]) err = 1'b1;
                else            data = {16'h0, half_v};
            end
            F3_LW: begin
                if (addr_lo != 2'b00) err = 1'b1;
                else                  data = word;
            end
            default: err = 1'b1;
        endcase
    end

endmodule

// File: rtl/dmem_responder.sv
// Memory-side responder: one load in flight with fixed latency, a
// single-cycle writeback pulse, committed byte-masked stores with
// store-to-load bypass at capture, and mispredict squash of younger loads.
module dmem_responder
    import types_pkg::*;
#(
    parameter int DEPTH_WORDS = 256,
    parameter int LOAD_LAT    = 2
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic [31:0] req_addr,
    input  logic [2:0]  req_funct3,
    input  logic [6:0]  req_pd,
    input  logic [4:0]  req_rob,
    input  logic        st_valid,
    input  logic [31:0] st_addr,
    input  logic [31:0] st_data,
    input  logic [2:0]  st_funct3,
    input  logic        mispredict,
    input  logic [4:0]  mispredict_tag,
    input  logic [4:0]  rob_head,
    output logic        resp_valid,
    output logic [6:0]  resp_pd,
    output logic [4:0]  resp_rob,
    output logic [31:0] resp_data,
    output logic        resp_err
);

    localparam int AW = $clog2(DEPTH_WORDS);
    localparam int CW = (LOAD_LAT > 2) ? $clog2(LOAD_LAT - 1) : 1;
    localparam logic [CW-1:0] CNT_INIT = CW'((LOAD_LAT > 2) ? LOAD_LAT - 2 : 0);
    localparam dmem_state_t START_STATE = (LOAD_LAT == 1) ? RESP : WAIT;

    logic [31:0] mem [DEPTH_WORDS];

    dmem_state_t state, state_nxt;
    logic [CW-1:0] cnt_q, cnt_nxt;
    dmem_req_t   req_in, lat_q, cap_req;

    logic          accept, younger, flush, capture;
    logic [AW-1:0] st_idx, cap_idx;
    logic [3:0]    st_be;
    logic [31:0]   st_wdata, cap_word, ext_data;
    logic          ext_err;
    logic          unused_addr_hi;

    assign req_in  = '{addr: req_addr, funct3: req_funct3, pd: req_pd, rob: req_rob};
    assign st_idx  = st_addr[AW+1:2];
    assign st_be   = st_valid ? store_be(st_funct3, st_addr[1:0]) : 4'b0000;
    assign st_wdata = store_lanes(st_funct3, st_data);

    assign younger   = rob_age(lat_q.rob, rob_head) > rob_age(mispredict_tag, rob_head);
    assign flush     = mispredict && younger;
    assign req_ready = (state == IDLE || state == RESP) && !mispredict;
    assign accept    = req_valid && req_ready;

    // Upper address bits wrap; only the word index and lane bits matter.
    assign unused_addr_hi = ^{st_addr[31:AW+2], cap_req.addr[31:AW+2]};

    // Next state, wait countdown and the (flushable) response pulse.
    always_comb begin
        state_nxt  = state;
        cnt_nxt    = cnt_q;
        resp_valid = 1'b0;
        case (state)
            IDLE: begin
                if (accept) begin
                    state_nxt = START_STATE;
                    cnt_nxt   = CNT_INIT;
                end
            end
            WAIT: begin
                if (flush)               state_nxt = IDLE;
                else if (cnt_q == '0)    state_nxt = RESP;
                else                     cnt_nxt   = cnt_q - CW'(1);
            end
            RESP: begin
                resp_valid = !flush;
                state_nxt  = IDLE;
                if (accept) begin
                    state_nxt = START_STATE;
                    cnt_nxt   = CNT_INIT;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    // Capture happens on the edge entering RESP; with single-cycle latency
    // the request is still on the input pins at that edge.
    assign capture = (state_nxt == RESP);
    assign cap_req = accept ? req_in : lat_q;
    assign cap_idx = cap_req.addr[AW+1:2];

    // Read the target word, merging a same-edge store so the load sees it.
    always_comb begin
        cap_word = mem[cap_idx];
        if (st_idx == cap_idx) begin
            for (int b = 0; b < 4; b++) begin
                if (st_be[b]) cap_word[8*b +: 8] = st_wdata[8*b +: 8];
            end
        end
    end

    dmem_lane_extract u_extract (
        .word    (cap_word),
        .funct3  (cap_req.funct3),
        .addr_lo (cap_req.addr[1:0]),
        .data    (ext_data),
        .err     (ext_err)
    );

    // FSM state, latched request and registered response fields.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state     <= IDLE;
            cnt_q     <= '0;
            lat_q     <= '0;
            resp_pd   <= '0;
            resp_rob  <= '0;
            resp_data <= '0;
            resp_err  <= 1'b0;
        end else begin
            state <= state_nxt;
            cnt_q <= cnt_nxt;
            if (accept) lat_q <= req_in;
            if (capture) begin
                resp_pd   <= cap_req.pd;
                resp_rob  <= cap_req.rob;
                resp_data <= ext_data;
                resp_err  <= ext_err;
            end
        end
    end

    // Committed stores always write; the array keeps its contents across reset.
    always_ff @(posedge clk) begin
        for (int b = 0; b < 4; b++) begin
            if (st_be[b]) mem[st_idx][8*b +: 8] <= st_wdata[8*b +: 8];
        end
    end

endmodule

// File: tb/tb_dmem_responder.sv
// Bench for dmem_responder: byte-level memory model plus a one-load
// timing model feed a scoreboard queue; a negedge monitor checks
// req_ready every cycle and pops/compares each response pulse.
module tb_dmem_responder;

    localparam int DEPTH = 256;
    localparam int LAT   = 2;
    localparam int NB    = DEPTH * 4;

    logic        clk, reset;
    logic        req_valid, req_ready;
    logic [31:0] req_addr;
    logic [2:0]  req_funct3;
    logic [6:0]  req_pd;
    logic [4:0]  req_rob;
    logic        st_valid;
    logic [31:0] st_addr, st_data;
    logic [2:0]  st_funct3;
    logic        mispredict;
    logic [4:0]  mispredict_tag, rob_head;
    logic        resp_valid;
    logic [6:0]  resp_pd;
    logic [4:0]  resp_rob;
    logic [31:0] resp_data;
    logic        resp_err;

    dmem_responder #(.DEPTH_WORDS(DEPTH), .LOAD_LAT(LAT)) dut (
        .clk(clk), .reset(reset),
        .req_valid(req_valid), .req_ready(req_ready), .req_addr(req_addr),
        .req_funct3(req_funct3), .req_pd(req_pd), .req_rob(req_rob),
        .st_valid(st_valid), .st_addr(st_addr), .st_data(st_data), .st_funct3(st_funct3),
        .mispredict(mispredict), .mispredict_tag(mispredict_tag), .rob_head(rob_head),
        .resp_valid(resp_valid), .resp_pd(resp_pd), .resp_rob(resp_rob),
        .resp_data(resp_data), .resp_err(resp_err)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        logic [31:0] addr;
        logic [2:0]  f3;
        logic [6:0]  pd;
        logic [4:0]  rob;
        int          acc;
        logic [31:0] data;
        logic        err;
    } ld_t;

    typedef struct {
        int          cyc;
        logic [6:0]  pd;
        logic [4:0]  rob;
        logic [31:0] data;
        logic        err;
    } exp_t;

    logic [7:0] mb [NB];
    exp_t sb[$];
    ld_t  pend;
    bit   pend_v = 0;
    bit   last_acc = 0;
    bit   exp_ready = 1;
    bit   done = 0;
    bit   final_done = 0;
    int   total = 0;
    int   bad = 0;

    function automatic int bidx(input logic [31:0] a);
        return int'(a % NB);
    endfunction

    function automatic bit is_younger(input logic [4:0] rob, input logic [4:0] tag, input logic [4:0] head);
        int ar, at;
        ar = (int'(rob) - int'(head) + 32) % 32;
        at = (int'(tag) - int'(head) + 32) % 32;
        return ar > at;
    endfunction

    task automatic model_store(input logic [31:0] a, input logic [31:0] d, input logic [2:0] f);
        logic [31:0] base;
        case (f)
            3'b000: mb[bidx(a)] = d[7:0];
            3'b001: begin
                base = a & ~32'd1;
                mb[bidx(base)]     = d[7:0];
                mb[bidx(base + 1)] = d[15:8];
            end
            3'b010: begin
                base = a & ~32'd3;
                for (int i = 0; i < 4; i++) mb[bidx(base + 32'(i))] = d[8*i +: 8];
            end
            default: ;
        endcase
    endtask

    task automatic model_load(input logic [31:0] a, input logic [2:0] f,
                              output logic [31:0] d, output logic e);
        logic [7:0]  b;
        logic [15:0] h;
        logic [31:0] w, wa;
        d  = 32'h0;
        e  = 1'b0;
        wa = a & ~32'd3;
        b  = mb[bidx(a)];
        h  = {mb[bidx((a & ~32'd1) + 1)], mb[bidx(a & ~32'd1)]};
        w  = {mb[bidx(wa + 3)], mb[bidx(wa + 2)], mb[bidx(wa + 1)], mb[bidx(wa)]};
        case (f)
            3'b000: d = {{24{b[7]}}, b};
            3'b100: d = {24'h0, b};
            3'b001: if (a[0]) e = 1'b1; else d = {{16{h[15]}}, h};
            3'b101: if (a[0]) e = 1'b1; else d = {16'h0, h};
            3'b010: if (a[1:0] != 2'b00) e = 1'b1; else d = w;
            default: e = 1'b1;
        endcase
    endtask

    // One cycle: apply inputs, predict ready and any response, then account the edge.
    task automatic cycle(input logic rv, input logic [31:0] ra, input logic [2:0] rf,
                         input logic [6:0] rp, input logic [4:0] rr,
                         input logic sv, input logic [31:0] sa, input logic [31:0] sd,
                         input logic [2:0] sf, input logic mp, input logic [4:0] mt,
                         input logic [4:0] rh);
        req_valid = rv; req_addr = ra; req_funct3 = rf; req_pd = rp; req_rob = rr;
        st_valid = sv; st_addr = sa; st_data = sd; st_funct3 = sf;
        mispredict = mp; mispredict_tag = mt; rob_head = rh;
        if (reset) pend_v = 0;
        exp_ready = !mp && (!pend_v || cyc == pend.acc + LAT);
        if (pend_v && cyc == pend.acc + LAT && !(mp && is_younger(pend.rob, mt, rh)))
            sb.push_back('{cyc, pend.pd, pend.rob, pend.data, pend.err});
        @(posedge clk);
        #1;
        last_acc = 0;
        if (reset) begin
            pend_v = 0;
        end else begin
            if (st_valid) model_store(st_addr, st_data, st_funct3);
            if (pend_v && mispredict && cyc - 1 > pend.acc &&
                is_younger(pend.rob, mispredict_tag, rob_head)) pend_v = 0;
            if (pend_v && cyc - 1 >= pend.acc + LAT) pend_v = 0;
            last_acc = req_valid && exp_ready;
            if (last_acc) begin
                pend.addr = req_addr; pend.f3 = req_funct3; pend.pd = req_pd;
                pend.rob = req_rob; pend.acc = cyc - 1;
                pend_v = 1;
            end
            if (pend_v && cyc - 1 == pend.acc + LAT - 1)
                model_load(pend.addr, pend.f3, pend.data, pend.err);
        end
    endtask

    task automatic idle(input int n);
        repeat (n) cycle(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    endtask

    task automatic store(input logic [31:0] a, input logic [31:0] d, input logic [2:0] f);
        cycle(0, 0, 0, 0, 0, 1, a, d, f, 0, 0, 0);
    endtask

    // Present a load until the model says it was taken (bounded).
    task automatic issue(input logic [31:0] a, input logic [2:0] f, input logic [6:0] p, input logic [4:0] r);
        int n;
        n = 0;
        cycle(1, a, f, p, r, 0, 0, 0, 0, 0, 0, 0);
        while (!last_acc && n < 20) begin
            cycle(1, a, f, p, r, 0, 0, 0, 0, 0, 0, 0);
            n++;
        end
    endtask

    // Monitor: ready every cycle, zeroed outputs in reset, scoreboard on each pulse.
    always @(negedge clk) begin
        if (!done) begin
            total++;
            if (req_ready !== exp_ready) begin
                bad++;
                $display("FAIL ready cyc=%0d got=%0b want=%0b", cyc, req_ready, exp_ready);
            end
            if (reset) begin
                total++;
                if ({resp_valid, resp_pd, resp_rob, resp_data, resp_err} !== 46'h0) begin
                    bad++;
                    $display("FAIL reset_out cyc=%0d got v=%0b pd=%0d rob=%0d data=%h err=%0b want all zero",
                             cyc, resp_valid, resp_pd, resp_rob, resp_data, resp_err);
                end
            end else begin
                if (sb.size() > 0 && sb[0].cyc < cyc) begin
                    total++;
                    bad++;
                    $display("FAIL missing_resp cyc=%0d got no pulse want pulse at cyc=%0d", cyc, sb[0].cyc);
                    void'(sb.pop_front());
                end
                if (resp_valid) begin
                    total++;
                    if (sb.size() == 0 || sb[0].cyc != cyc) begin
                        bad++;
                        $display("FAIL unexpected_resp cyc=%0d got pulse pd=%0d rob=%0d want none", cyc, resp_pd, resp_rob);
                    end else begin
                        exp_t e;
                        e = sb.pop_front();
                        if ({resp_pd, resp_rob, resp_data, resp_err} !== {e.pd, e.rob, e.data, e.err}) begin
                            bad++;
                            $display("FAIL resp cyc=%0d got pd=%0d rob=%0d data=%h err=%0b want pd=%0d rob=%0d data=%h err=%0b",
                                     cyc, resp_pd, resp_rob, resp_data, resp_err, e.pd, e.rob, e.data, e.err);
                        end
                    end
                end
            end
        end else if (!final_done) begin
            final_done = 1;
            total++;
            if (sb.size() != 0) begin
                bad++;
                $display("FAIL leftover_resp got %0d undelivered want 0", sb.size());
            end
        end
    end

    initial begin
        logic [2:0]  lf [5];
        logic [31:0] b2b [4];
        logic [31:0] a;
        int          i, n;
        lf  = '{3'b000, 3'b001, 3'b010, 3'b100, 3'b101};
        b2b = '{32'h10, 32'h20, 32'h24, 32'h104};
        req_valid = 0; req_addr = 0; req_funct3 = 0; req_pd = 0; req_rob = 0;
        st_valid = 0; st_addr = 0; st_data = 0; st_funct3 = 0;
        mispredict = 0; mispredict_tag = 0; rob_head = 0;
        reset = 1;
        idle(3);
        reset = 0;
        idle(2);

        // Give every word a known value.
        for (int w = 0; w < DEPTH; w++) store(32'(w * 4), $urandom, 3'b010);
        idle(1);

        // Word load and the four narrow extensions of the same word.
        store(32'h10, 32'hDEADBEEF, 3'b010);
        issue(32'h10, 3'b010, 7'd11, 5'd1);  idle(2);
        issue(32'h13, 3'b000, 7'd12, 5'd2);  idle(2);
        issue(32'h13, 3'b100, 7'd13, 5'd3);  idle(2);
        issue(32'h12, 3'b001, 7'd14, 5'd4);  idle(2);
        issue(32'h10, 3'b101, 7'd15, 5'd5);  idle(2);

        // Store bypass into the capture edge; other-word store alongside.
        issue(32'h20, 3'b010, 7'd20, 5'd6);
        store(32'h21, 32'h00000055, 3'b000);
        idle(2);
        issue(32'h30, 3'b010, 7'd21, 5'd7);
        store(32'h35, 32'h000000AA, 3'b000);
        idle(2);

        // Younger load squashed in WAIT; older load survives.
        issue(32'h10, 3'b010, 7'd30, 5'd9);
        cycle(0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 5'd6, 5'd3);
        idle(3);
        issue(32'h10, 3'b010, 7'd31, 5'd5);
        cycle(0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 5'd6, 5'd3);
        idle(3);
        // Younger load squashed in its response cycle.
        issue(32'h14, 3'b010, 7'd32, 5'd20);
        idle(1);
        cycle(0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 5'd10, 5'd0);
        idle(2);

        // Misaligned loads.
        issue(32'h22, 3'b010, 7'd40, 5'd8);  idle(2);
        issue(32'h11, 3'b001, 7'd41, 5'd9);  idle(2);
        issue(32'h12, 3'b011, 7'd42, 5'd10); idle(2);

        // Back-to-back loads held valid continuously.
        i = 0; n = 0;
        while (i < 4 && n < 40) begin
            cycle(1, b2b[i], 3'b010, 7'(50 + i), 5'(i), 0, 0, 0, 0, 0, 0, 0);
            n++;
            if (last_acc) i++;
        end
        idle(3);

        // Same again, with reset landing in the second load's wait.
        i = 0; n = 0;
        while (i < 4 && n < 40) begin
            cycle(1, b2b[i], 3'b010, 7'(60 + i), 5'(i), 0, 0, 0, 0, 0, 0, 0);
            n++;
            if (last_acc) i++;
            if (last_acc && i == 2) break;
        end
        reset = 1;
        idle(2);
        reset = 0;
        idle(1);
        for (int k = 0; k < 4; k++) begin
            issue(b2b[k], 3'b010, 7'(70 + k), 5'(k));
            idle(2);
        end

        // Random traffic with wrapped addresses, stores, flushes.
        for (int k = 0; k < 3000; k++) begin
            logic        rv, sv, mp;
            logic [2:0]  rf, sf;
            logic [31:0] ra, sa;
            rv = ($urandom_range(0, 99) < 70);
            ra = ($urandom & 32'hFFFF_FC00) | 32'($urandom_range(0, 63));
            if ($urandom_range(0, 1) == 1) ra = ra & ~32'd3;
            rf = ($urandom_range(0, 9) < 9) ? lf[$urandom_range(0, 4)] : 3'($urandom_range(0, 7));
            sv = ($urandom_range(0, 99) < 35);
            sa = ($urandom & 32'hFFFF_FC00) | 32'($urandom_range(0, 63));
            sf = 3'($urandom_range(0, 3));
            mp = ($urandom_range(0, 99) < 10);
            a  = $urandom;
            cycle(rv, ra, rf, 7'($urandom), 5'($urandom), sv, sa, a, sf,
                  mp, 5'($urandom), 5'($urandom));
        end

        idle(5);
        done = 1;
        idle(2);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
